// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared FSM states and data widths for the program loader
package instr_mem_loader_pkg;
    localparam int INSTR_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WR_LO  = 3'd2,
        WR_HI  = 3'd3,
        FINISH = 3'd4
    } state_t;
endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 16-bit words into byte-addressed instruction memory, stalling then killing the CPU
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_BYTES = 256,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [INSTR_W-1:0]    in_word,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BYTE_W-1:0]     wr_data,
    output logic                  cpu_stall,
    output logic                  cpu_kill,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] word_count
);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_BYTES - 2);
    state_t state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [INSTR_W-1:0] word;
    logic last;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= '0;
            word <= '0;
            last <= 1'b0;
            overflow <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ptr <= ADDR_WIDTH'(START_ADDR);
                    word_count <= '0;
                    overflow <= 1'b0;
                    state <= LOAD;
                end
                LOAD: if (in_valid) begin
                    word <= in_word;
                    last <= in_last;
                    // a word past the end is dropped so ptr can never wrap
                    overflow <= ptr > LAST_WORD;
                    state <= ptr > LAST_WORD ? FINISH : WR_LO;
                end
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    ptr <= ptr + ADDR_WIDTH'(2);
                    word_count <= word_count + ADDR_WIDTH'(1);
                    state <= last ? FINISH : LOAD;
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        in_ready = state == LOAD;
        wr_en = state == WR_LO || state == WR_HI;
        wr_addr = state == WR_LO ? ptr : state == WR_HI ? ptr + ADDR_WIDTH'(1) : '0;
        wr_data = state == WR_LO ? word[BYTE_W-1:0] : state == WR_HI ? word[INSTR_W-1:BYTE_W] : '0;
        cpu_stall = state != IDLE;
        cpu_kill = state == FINISH;
        done = state == FINISH;
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed loads checked against a byte-write scoreboard
module tb_instr_mem_loader;
    localparam int AW = 16;
    localparam int MB = 8;
    logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
    logic [15:0] in_word = '0;
    logic in_ready, wr_en, cpu_stall, cpu_kill, done, overflow;
    logic [AW-1:0] wr_addr, word_count;
    logic [7:0] wr_data;
    int checks = 0, failures = 0, done_cnt = 0, exp_ptr = 0, exp_wc = 0, w;
    logic [23:0] sb[$];

    instr_mem_loader #(.ADDR_WIDTH(AW), .MEM_BYTES(MB), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_word(in_word),
        .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_stall(cpu_stall), .cpu_kill(cpu_kill), .done(done),
        .overflow(overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (wr_en) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_write observed=%0h expected=none", {wr_addr, wr_data});
            end else chk("write", {wr_addr, wr_data}, sb.pop_front());
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_cpu_stall"}, cpu_stall, 0);
        chk({tag, "_cpu_kill"}, cpu_kill, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic do_start();
        start = 1;
        @(posedge clk); #1 start = 0;
        exp_ptr = 0;
        exp_wc = 0;
        @(negedge clk);
        chk("start_in_ready", in_ready, 1);
        chk("start_overflow", overflow, 0);
        chk("start_word_count", word_count, 0);
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] wd, input logic lst, input bit hold, output int waited);
        in_valid = 1;
        in_word = wd;
        in_last = lst;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        chk("handshake_ready", in_ready, 1);
        chk("handshake_stall", cpu_stall, 1);
        if (exp_ptr <= MB - 2) begin
            sb.push_back({16'(exp_ptr), wd[7:0]});
            sb.push_back({16'(exp_ptr + 1), wd[15:8]});
            exp_ptr += 2;
            exp_wc++;
        end
        @(posedge clk); #1;
        if (!hold) in_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!done && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_kill"}, cpu_kill, 1);
        chk({tag, "_word_count"}, word_count, 32'(exp_wc));
        @(negedge clk);
        chk({tag, "_idle_stall"}, cpu_stall, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 reset = 0;

        do_start();
        send(16'h4DC0, 1, 0, w);
        repeat (3) @(negedge clk);
        chk("single_done_t3", done, 1);
        chk("single_kill_t3", cpu_kill, 1);
        chk("single_word_count", word_count, 1);
        @(negedge clk);
        chk("single_idle_stall", cpu_stall, 0);
        chk("single_idle_done", done, 0);
        @(posedge clk); #1;

        do_start();
        send(16'h1234, 0, 1, w);
        send(16'hABCD, 0, 1, w);
        chk("burst_gap2", w, 2);
        send(16'h0F0F, 1, 0, w);
        chk("burst_gap3", w, 2);
        wait_done("burst");

        do_start();
        send(16'hA1B2, 0, 0, w);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap_wr_en", wr_en, 0);
            chk("gap_in_ready", in_ready, 1);
        end
        @(posedge clk); #1;
        send(16'hC3D4, 1, 0, w);
        chk("gap_resume_wait", w, 0);
        wait_done("gap");

        do_start();
        send(16'h1111, 0, 0, w);
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        send(16'h2222, 1, 0, w);
        wait_done("start_in_load");

        do_start();
        for (int i = 0; i < 4; i++) send(16'h0101 * 16'(i + 3), 0, 0, w);
        send(16'hDEAD, 1, 0, w);
        @(negedge clk);
        chk("ovf_done", done, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_wr_en", wr_en, 0);
        chk("ovf_word_count", word_count, 4);
        @(negedge clk);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_idle_stall", cpu_stall, 0);
        @(posedge clk); #1;

        do_start();
        send(16'h5A5A, 0, 0, w);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        do_start();
        send(16'h7788, 1, 0, w);
        wait_done("reload");

        reset = 1;
        start = 1;
        @(posedge clk); #1 reset = 0; start = 0;
        @(negedge clk);
        chk("reset_wins_ready", in_ready, 0);
        chk("reset_wins_stall", cpu_stall, 0);
        repeat (3) @(negedge clk);
        chk("done_pulses", done_cnt, 6);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
